// File: rtl/answer_entry_ctrl.sv
// Keypad answer-entry controller: synchronised, edge-detected key events edit a
// BCD digit buffer that is committed to the game core through a valid/ready handshake.
module answer_entry_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter bit ALLOW_REPEAT = 1'b0,
    parameter int CW           = $clog2(NUM_DIGITS + 1)
) (
    input  logic                    CLK,
    input  logic                    rst_n,
    input  logic [9:0]              key,
    input  logic                    del_key,
    input  logic                    clr_key,
    input  logic                    enter_key,
    input  logic                    answer_ready,
    output logic [4*NUM_DIGITS-1:0] answer,
    output logic [CW-1:0]           digit_count,
    output logic                    legal,
    output logic                    answer_valid,
    output logic                    reject
);

    localparam int AW = 4 * NUM_DIGITS;

    typedef enum logic {ENTRY, HOLD} state_t;
    state_t state;

    logic [12:0] raw, sync1, sync2, prev, rise;
    logic [9:0]  key_rise;
    logic        del_ev, clr_ev, ent_ev, digit_ev, digit_multi;
    logic [3:0]  digit_val;
    logic        dup, full, legal_next;

    assign raw = {enter_key, clr_key, del_key, key};

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign rise        = sync2 & ~prev;
    assign key_rise    = rise[9:0];
    assign del_ev      = rise[10];
    assign clr_ev      = rise[11];
    assign ent_ev      = rise[12];
    assign digit_ev    = |key_rise;
    assign digit_multi = (key_rise & (key_rise - 10'd1)) != '0;

    always_comb begin
        digit_val = '0;
        for (int unsigned i = 0; i < 10; i++)
            if (key_rise[i]) digit_val = 4'(i);
    end

    always_comb begin
        dup = 1'b0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++)
            for (int unsigned j = i + 1; j < NUM_DIGITS; j++)
                if (answer[4*i +: 4] == answer[4*j +: 4]) dup = 1'b1;
    end

    assign full       = (digit_count == CW'(NUM_DIGITS));
    assign legal_next = full && (ALLOW_REPEAT || !dup);

    // Events are prioritised clr > del > enter > digit; lower ones in the same cycle are dropped.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ENTRY;
            answer       <= '1;
            digit_count  <= '0;
            legal        <= 1'b0;
            answer_valid <= 1'b0;
            reject       <= 1'b0;
        end else begin
            reject <= 1'b0;
            legal  <= legal_next;
            case (state)
                ENTRY: begin
                    if (clr_ev) begin
                        answer      <= '1;
                        digit_count <= '0;
                    end else if (del_ev) begin
                        if (digit_count != '0) begin
                            answer      <= {4'hF, answer[AW-1:4]};
                            digit_count <= digit_count - CW'(1);
                        end
                    end else if (ent_ev) begin
                        if (legal) begin
                            state        <= HOLD;
                            answer_valid <= 1'b1;
                        end else begin
                            reject <= 1'b1;
                        end
                    end else if (digit_ev) begin
                        if (digit_multi || full) begin
                            reject <= 1'b1;
                        end else begin
                            answer      <= {answer[AW-5:0], digit_val};
                            digit_count <= digit_count + CW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (clr_ev || (answer_valid && answer_ready)) begin
                        state        <= ENTRY;
                        answer_valid <= 1'b0;
                        answer       <= '1;
                        digit_count  <= '0;
                    end
                    if (!clr_ev && (del_ev || ent_ev || digit_ev)) reject <= 1'b1;
                end
                default: state <= ENTRY;
            endcase
        end
    end

endmodule
